// File: rtl/issue_slot.sv
// -----------------------------------------------------------------------------
// issue_slot
// One reservation-station entry of the issue queue. It holds a single
// dispatched uop, watches the writeback wakeup ports to learn when its source
// operands become ready, and raises a request to the select logic once
// everything is ready. Branch resolve/kill and pipeline flush are handled
// here as well.
//
// Optional feature macro: ISSUE_SLOT_PPRED_EN
//   When defined, the slot also tracks a predicate operand (in_ppred,
//   in_ppred_busy, pred_wk_valid, pred_wk_id, out_ppred). The predicate busy
//   bit gates request exactly like the register operands. When undefined,
//   those ports do not exist and request ignores predicate state.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   dispatch handshake (in_ready = slot empty)
//   in_uopc .. in_br_mask  uop fields captured on insert
//   wk_valid/wk_pdst    per-port writeback wakeup strobes and tags
//   br_resolve_mask     branches resolved correctly this cycle
//   br_kill_mask        branches mispredicted this cycle
//   flush               pipeline flush
//   request/grant       issue request to select, grant back
//   out_valid, out_*    slot occupancy and stored uop fields
//   out_br_mask         stored mask with this cycle's resolves already removed
// -----------------------------------------------------------------------------
module issue_slot #(
    parameter int NUM_WAKEUP = 2,
    parameter int PREG_W     = 7,
    parameter int BR_MASK_W  = 12,
    parameter int UOPC_W     = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [UOPC_W-1:0]            in_uopc,
    input  logic [31:0]                  in_inst,
    input  logic [PREG_W-1:0]            in_pdst,
    input  logic [PREG_W-1:0]            in_prs1,
    input  logic [PREG_W-1:0]            in_prs2,
    input  logic                         in_prs1_busy,
    input  logic                         in_prs2_busy,
    input  logic [BR_MASK_W-1:0]         in_br_mask,
    input  logic [NUM_WAKEUP-1:0]        wk_valid,
    input  logic [NUM_WAKEUP*PREG_W-1:0] wk_pdst,
    input  logic [BR_MASK_W-1:0]         br_resolve_mask,
    input  logic [BR_MASK_W-1:0]         br_kill_mask,
    input  logic                         flush,
    output logic                         request,
    input  logic                         grant,
    output logic                         out_valid,
    output logic [UOPC_W-1:0]            out_uopc,
    output logic [31:0]                  out_inst,
    output logic [PREG_W-1:0]            out_pdst,
    output logic [PREG_W-1:0]            out_prs1,
    output logic [PREG_W-1:0]            out_prs2,
`ifdef ISSUE_SLOT_PPRED_EN
    input  logic [4:0]                   in_ppred,
    input  logic                         in_ppred_busy,
    input  logic                         pred_wk_valid,
    input  logic [4:0]                   pred_wk_id,
    output logic [4:0]                   out_ppred,
`endif
    output logic [BR_MASK_W-1:0]         out_br_mask
);

    typedef enum logic {
        S_EMPTY    = 1'b0,
        S_OCCUPIED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [UOPC_W-1:0]     uopc_q, uopc_d;
    logic [31:0]           inst_q, inst_d;
    logic [PREG_W-1:0]     pdst_q, pdst_d;
    logic [PREG_W-1:0]     prs1_q, prs1_d;
    logic [PREG_W-1:0]     prs2_q, prs2_d;
    logic                  p1_busy_q, p1_busy_d;
    logic                  p2_busy_q, p2_busy_d;
    logic [BR_MASK_W-1:0]  br_mask_q, br_mask_d;

    // Wakeup tag compares: against the stored sources and against the
    // incoming uop's sources, so a same-cycle insert sees the wakeup too.
    logic [NUM_WAKEUP-1:0] hit_prs1, hit_prs2, hit_in1, hit_in2;

    for (genvar gi = 0; gi < NUM_WAKEUP; gi++) begin : g_wakeup
        assign hit_prs1[gi] = wk_valid[gi] && (wk_pdst[gi*PREG_W +: PREG_W] == prs1_q);
        assign hit_prs2[gi] = wk_valid[gi] && (wk_pdst[gi*PREG_W +: PREG_W] == prs2_q);
        assign hit_in1[gi]  = wk_valid[gi] && (wk_pdst[gi*PREG_W +: PREG_W] == in_prs1);
        assign hit_in2[gi]  = wk_valid[gi] && (wk_pdst[gi*PREG_W +: PREG_W] == in_prs2);
    end

    logic occupied;
    logic kill_hit;
    logic insert_ok;
    logic pred_ready;

`ifdef ISSUE_SLOT_PPRED_EN
    logic [4:0] ppred_q, ppred_d;
    logic       ppred_busy_q, ppred_busy_d;
    assign pred_ready = !ppred_busy_q;
    assign out_ppred  = ppred_q;
`else
    assign pred_ready = 1'b1;
`endif

    assign occupied  = (state_q == S_OCCUPIED);
    // Kill looks at the raw stored mask: a bit in both resolve and kill is a kill.
    assign kill_hit  = occupied && |(br_mask_q & br_kill_mask);
    assign insert_ok = !occupied && in_valid && !flush && !(|(in_br_mask & br_kill_mask));

    // Purely combinational, so a kill or flush suppresses request in the same cycle.
    assign request   = occupied && !p1_busy_q && !p2_busy_q && pred_ready && !kill_hit && !flush;

    assign in_ready    = !occupied;
    assign out_valid   = occupied;
    assign out_uopc    = uopc_q;
    assign out_inst    = inst_q;
    assign out_pdst    = pdst_q;
    assign out_prs1    = prs1_q;
    assign out_prs2    = prs2_q;
    assign out_br_mask = br_mask_q & ~br_resolve_mask;

    always_comb begin
        state_d   = state_q;
        uopc_d    = uopc_q;
        inst_d    = inst_q;
        pdst_d    = pdst_q;
        prs1_d    = prs1_q;
        prs2_d    = prs2_q;
        p1_busy_d = p1_busy_q;
        p2_busy_d = p2_busy_q;
        br_mask_d = br_mask_q;
`ifdef ISSUE_SLOT_PPRED_EN
        ppred_d      = ppred_q;
        ppred_busy_d = ppred_busy_q;
`endif
        if (flush || kill_hit) begin
            state_d = S_EMPTY;
        end else if (request && grant) begin
            // Fields stay put; the slot is simply marked free. No reuse this cycle.
            state_d = S_EMPTY;
        end else if (occupied) begin
            p1_busy_d = p1_busy_q && !(|hit_prs1);
            p2_busy_d = p2_busy_q && !(|hit_prs2);
            br_mask_d = br_mask_q & ~br_resolve_mask;
`ifdef ISSUE_SLOT_PPRED_EN
            ppred_busy_d = ppred_busy_q && !(pred_wk_valid && (pred_wk_id == ppred_q));
`endif
        end else if (insert_ok) begin
            state_d   = S_OCCUPIED;
            uopc_d    = in_uopc;
            inst_d    = in_inst;
            pdst_d    = in_pdst;
            prs1_d    = in_prs1;
            prs2_d    = in_prs2;
            p1_busy_d = in_prs1_busy && !(|hit_in1);
            p2_busy_d = in_prs2_busy && !(|hit_in2);
            br_mask_d = in_br_mask & ~br_resolve_mask;
`ifdef ISSUE_SLOT_PPRED_EN
            ppred_d      = in_ppred;
            ppred_busy_d = in_ppred_busy && !(pred_wk_valid && (pred_wk_id == in_ppred));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            uopc_q    <= '0;
            inst_q    <= '0;
            pdst_q    <= '0;
            prs1_q    <= '0;
            prs2_q    <= '0;
            p1_busy_q <= 1'b0;
            p2_busy_q <= 1'b0;
            br_mask_q <= '0;
`ifdef ISSUE_SLOT_PPRED_EN
            ppred_q      <= '0;
            ppred_busy_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            uopc_q    <= uopc_d;
            inst_q    <= inst_d;
            pdst_q    <= pdst_d;
            prs1_q    <= prs1_d;
            prs2_q    <= prs2_d;
            p1_busy_q <= p1_busy_d;
            p2_busy_q <= p2_busy_d;
            br_mask_q <= br_mask_d;
`ifdef ISSUE_SLOT_PPRED_EN
            ppred_q      <= ppred_d;
            ppred_busy_q <= ppred_busy_d;
`endif
        end
    end

endmodule
